// File: rtl/uart_receiver.sv
// 8N1 UART receive deframer: synchronises rx, oversamples each bit and pushes good bytes
// into an RX FIFO write port, with sticky framing-error and overrun flags.
module uart_receiver #(
   parameter int CLK_HZ     = 50_000_000,
   parameter int BAUD       = 115200,
   parameter int OVERSAMPLE = 16
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       rx,
   input  logic       fifo_full,
   output logic [7:0] fifo_data,
   output logic       fifo_write_en,
   input  logic       i_clr_err,
   output logic       o_frame_err,
   output logic       o_overrun,
   output logic       o_busy
);

   localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);
   localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int SW  = $clog2(OVERSAMPLE);
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
   localparam logic [SW-1:0] SC_MID   = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] SC_LAST  = SW'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      DONE  = 3'd4,
      BREAK = 3'd5
   } state_t;

   state_t          state_q;
   logic            rx_meta_q;
   logic            rx_s_q;
   logic [DW-1:0]   div_q;
   logic [DW-1:0]   div_d;
   logic            tick_s;
   logic [SW-1:0]   sc_q;
   logic [2:0]      bc_q;
   logic [7:0]      shift_q;
   logic [7:0]      fifo_data_q;
   logic            fifo_write_en_q;
   logic            frame_err_q;
   logic            overrun_q;
   logic            busy_q;

   assign fifo_data     = fifo_data_q;
   assign fifo_write_en = fifo_write_en_q;
   assign o_frame_err   = frame_err_q;
   assign o_overrun     = overrun_q;
   assign o_busy        = busy_q;

   // Two-flop synchroniser; resets to the idle-high line level so release never looks like a start bit.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
      end
   end

   assign tick_s = (div_q == DIV_LAST);

   // Oversample tick divider, parked at zero while idle so the first tick lands DIV clocks after the start edge.
   always_comb begin
      div_d = div_q;
      if (state_q == IDLE) begin
         div_d = '0;
      end else if (tick_s) begin
         div_d = '0;
      end else begin
         div_d = div_q + DW'(1);
      end
   end

   // Deframing FSM with registered FIFO strobe, data and sticky flags; a set event beats a same-cycle clear.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q         <= IDLE;
         div_q           <= '0;
         sc_q            <= '0;
         bc_q            <= 3'd0;
         shift_q         <= 8'h00;
         fifo_data_q     <= 8'h00;
         fifo_write_en_q <= 1'b0;
         frame_err_q     <= 1'b0;
         overrun_q       <= 1'b0;
         busy_q          <= 1'b0;
      end else begin
         div_q           <= div_d;
         fifo_write_en_q <= 1'b0;
         if (i_clr_err) begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
         end
         case (state_q)
            IDLE: begin
               if (!rx_s_q) begin
                  sc_q    <= '0;
                  bc_q    <= 3'd0;
                  state_q <= START;
                  busy_q  <= 1'b1;
               end
            end
            START: begin
               if (tick_s) begin
                  if (sc_q == SC_MID) begin
                     sc_q <= '0;
                     bc_q <= 3'd0;
                     if (rx_s_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                     end else begin
                        state_q <= DATA;
                     end
                  end else begin
                     sc_q <= sc_q + SW'(1);
                  end
               end
            end
            DATA: begin
               if (tick_s) begin
                  if (sc_q == SC_LAST) begin
                     sc_q          <= '0;
                     shift_q[bc_q] <= rx_s_q;
                     if (bc_q == 3'd7) begin
                        state_q <= STOP;
                     end else begin
                        bc_q <= bc_q + 3'd1;
                     end
                  end else begin
                     sc_q <= sc_q + SW'(1);
                  end
               end
            end
            STOP: begin
               if (tick_s) begin
                  if (sc_q == SC_LAST) begin
                     sc_q <= '0;
                     if (rx_s_q) begin
                        state_q <= DONE;
                     end else begin
                        frame_err_q <= 1'b1;
                        state_q     <= BREAK;
                     end
                  end else begin
                     sc_q <= sc_q + SW'(1);
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               if (!fifo_full) begin
                  fifo_write_en_q <= 1'b1;
                  fifo_data_q     <= shift_q;
               end else begin
                  overrun_q <= 1'b1;
               end
            end
            BREAK: begin
               if (rx_s_q) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at default parameters: a table of single frames plus
// hand-written back-to-back, glitch, mid-frame reset and baud-offset sequences.
`timescale 1ns/1ps
module tb_uart_receiver;

   localparam int BIT_CLKS = 432;

   logic       i_clk     = 1'b0;
   logic       i_rst     = 1'b0;
   logic       rx        = 1'b1;
   logic       fifo_full = 1'b0;
   logic       i_clr_err = 1'b0;
   logic [7:0] fifo_data;
   logic       fifo_write_en;
   logic       o_frame_err;
   logic       o_overrun;
   logic       o_busy;

   int         tests = 0;
   int         fails = 0;
   logic [7:0] wq[$];

   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic       full;
      logic       clr;
      logic       exp_wr;
      logic       exp_fe;
      logic       exp_ov;
   } vec_t;

   vec_t vt[6];

   uart_receiver dut (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .rx            (rx),
      .fifo_full     (fifo_full),
      .fifo_data     (fifo_data),
      .fifo_write_en (fifo_write_en),
      .i_clr_err     (i_clr_err),
      .o_frame_err   (o_frame_err),
      .o_overrun     (o_overrun),
      .o_busy        (o_busy)
   );

   always #10 i_clk = ~i_clk;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Every strobed cycle becomes one queue entry, so a stretched strobe shows up as an extra write.
   always @(negedge i_clk) begin
      if (fifo_write_en === 1'b1) begin
         wq.push_back(fifo_data);
         chk("write_while_full", int'(fifo_full), 0);
      end
   end

   task automatic send_frame(input logic [7:0] d, input logic stop, input int bclk);
      rx = 1'b0;
      repeat (bclk) @(negedge i_clk);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         repeat (bclk) @(negedge i_clk);
      end
      rx = stop;
      repeat (bclk) @(negedge i_clk);
      rx = 1'b1;
   endtask

   task automatic expect_state(input string tag, input int nwr, input logic [7:0] d,
                               input logic fe, input logic ov);
      repeat (20) @(negedge i_clk);
      chk({tag, " writes"}, wq.size(), nwr);
      if (nwr == 1 && wq.size() == 1) chk({tag, " data"}, int'(wq[0]), int'(d));
      chk({tag, " frame_err"}, int'(o_frame_err), int'(fe));
      chk({tag, " overrun"}, int'(o_overrun), int'(ov));
      chk({tag, " busy"}, int'(o_busy), 0);
      wq.delete();
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0] = '{data: 8'hA5, stop: 1'b1, full: 1'b0, clr: 1'b0, exp_wr: 1'b1, exp_fe: 1'b0, exp_ov: 1'b0};
      vt[1] = '{data: 8'h3C, stop: 1'b0, full: 1'b0, clr: 1'b0, exp_wr: 1'b0, exp_fe: 1'b1, exp_ov: 1'b0};
      vt[2] = '{data: 8'h12, stop: 1'b1, full: 1'b0, clr: 1'b1, exp_wr: 1'b1, exp_fe: 1'b0, exp_ov: 1'b0};
      vt[3] = '{data: 8'h77, stop: 1'b1, full: 1'b1, clr: 1'b0, exp_wr: 1'b0, exp_fe: 1'b0, exp_ov: 1'b1};
      vt[4] = '{data: 8'h78, stop: 1'b1, full: 1'b0, clr: 1'b0, exp_wr: 1'b1, exp_fe: 1'b0, exp_ov: 1'b1};
      vt[5] = '{data: 8'h96, stop: 1'b1, full: 1'b0, clr: 1'b1, exp_wr: 1'b1, exp_fe: 1'b0, exp_ov: 1'b0};

      repeat (5) @(negedge i_clk);
      chk("reset write_en", int'(fifo_write_en), 0);
      chk("reset data", int'(fifo_data), 0);
      chk("reset frame_err", int'(o_frame_err), 0);
      chk("reset overrun", int'(o_overrun), 0);
      chk("reset busy", int'(o_busy), 0);
      i_rst = 1'b1;
      repeat (BIT_CLKS) @(negedge i_clk);

      for (int v = 0; v < 6; v++) begin
         fifo_full = vt[v].full;
         if (vt[v].clr) begin
            i_clr_err = 1'b1;
            @(negedge i_clk);
            i_clr_err = 1'b0;
            @(negedge i_clk);
            chk($sformatf("vec%0d cleared frame_err", v), int'(o_frame_err), 0);
            chk($sformatf("vec%0d cleared overrun", v), int'(o_overrun), 0);
         end
         repeat (BIT_CLKS) @(negedge i_clk);
         send_frame(vt[v].data, vt[v].stop, BIT_CLKS);
         expect_state($sformatf("vec%0d", v), int'(vt[v].exp_wr), vt[v].data,
                      vt[v].exp_fe, vt[v].exp_ov);
      end
      fifo_full = 1'b0;

      repeat (BIT_CLKS) @(negedge i_clk);
      send_frame(8'h00, 1'b1, BIT_CLKS);
      send_frame(8'hFF, 1'b1, BIT_CLKS);
      send_frame(8'h55, 1'b1, BIT_CLKS);
      repeat (20) @(negedge i_clk);
      chk("b2b writes", wq.size(), 3);
      if (wq.size() == 3) begin
         chk("b2b byte0", int'(wq[0]), 8'h00);
         chk("b2b byte1", int'(wq[1]), 8'hFF);
         chk("b2b byte2", int'(wq[2]), 8'h55);
      end
      chk("b2b frame_err", int'(o_frame_err), 0);
      chk("b2b overrun", int'(o_overrun), 0);
      wq.delete();

      // Low pulse of 3 oversample ticks is rejected by the mid-start-bit check.
      rx = 1'b0;
      repeat (40) @(negedge i_clk);
      chk("glitch busy during", int'(o_busy), 1);
      repeat (41) @(negedge i_clk);
      rx = 1'b1;
      repeat (300) @(negedge i_clk);
      expect_state("glitch", 0, 8'h00, 1'b0, 1'b0);

      fork
         send_frame(8'hE7, 1'b1, BIT_CLKS);
         begin
            repeat (5 * BIT_CLKS + 200) @(negedge i_clk);
            i_rst = 1'b0;
            @(negedge i_clk);
            chk("midreset busy", int'(o_busy), 0);
         end
      join
      repeat (200) @(negedge i_clk);
      i_rst = 1'b1;
      repeat (BIT_CLKS) @(negedge i_clk);
      chk("midreset writes", wq.size(), 0);
      send_frame(8'hC3, 1'b1, BIT_CLKS);
      expect_state("after_reset", 1, 8'hC3, 1'b0, 1'b0);

      repeat (BIT_CLKS) @(negedge i_clk);
      send_frame(8'h5A, 1'b1, 419);
      expect_state("baud_fast", 1, 8'h5A, 1'b0, 1'b0);
      repeat (BIT_CLKS) @(negedge i_clk);
      send_frame(8'h5A, 1'b1, 445);
      expect_state("baud_slow", 1, 8'h5A, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
